// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code sequencer: state encoding, default width
// and a reference binary-to-Gray function.
package gray_pkg;

    localparam int unsigned GRAY_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
    function automatic logic [GRAY_W-1:0] bin_to_gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// Control and valid/ready bus between a controller/consumer and gray_seq_ctrl.
//   master : drives start/stop/mode/dir/load/load_val/gray_ready
//   slave  : the sequencer; drives gray_out/gray_valid/bin_out/busy/wrap
interface gray_seq_ctrl_if
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_W
);
    logic             start;
    logic             stop;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] gray_out;
    logic             gray_valid;
    logic             gray_ready;
    logic [WIDTH-1:0] bin_out;
    logic             busy;
    logic             wrap;

    modport master (
        output start, stop, mode, dir, load, load_val, gray_ready,
        input  gray_out, gray_valid, bin_out, busy, wrap
    );

    modport slave (
        input  start, stop, mode, dir, load, load_val, gray_ready,
        output gray_out, gray_valid, bin_out, busy, wrap
    );
endinterface

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray converter, g[i] = b[i] ^ b[i+1], MSB passes through.
//   i_bin     : binary input
//   o_gray_c  : Gray-coded output (combinational)
module gray_enc #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray_c
);
    assign o_gray_c = i_bin ^ (i_bin >> 1);
endmodule

// File: rtl/gray_seq_ctrl.sv
// Gray-code sequencer: binary count register stepped up/down on each accepted
// handshake, offered downstream as Gray code over valid/ready.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of gray_seq_ctrl_if (control inputs, Gray output handshake,
//          binary observe, busy, wrap pulse)
module gray_seq_ctrl
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_W
) (
    input  logic            clk,
    input  logic            rst,
    gray_seq_ctrl_if.slave  bus
);
    state_e           r_state;
    logic [WIDTH-1:0] r_bin;
    logic             r_stop_pend;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_bin_nxt;
    logic             w_stop_pend_nxt;
    logic             w_wrap;
    logic             w_hs;
    logic [WIDTH-1:0] w_gray;

    // Valid is simply "in EMIT", so the handshake only needs ready from outside.
    assign w_hs = (r_state == ST_EMIT) && bus.gray_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bin       <= '0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bin       <= w_bin_nxt;
            r_stop_pend <= w_stop_pend_nxt;
        end
    end

    // Next-state, count update and wrap detection.
    always_comb begin
        w_state_nxt     = r_state;
        w_bin_nxt       = r_bin;
        w_stop_pend_nxt = r_stop_pend;
        w_wrap          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // stop is meaningless here; never arm a pending stop from IDLE.
                w_stop_pend_nxt = 1'b0;
                if (bus.load) begin
                    w_bin_nxt = bus.load_val;
                end
                if (bus.start) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_hs) begin
                    if (bus.dir) begin
                        w_bin_nxt = r_bin - WIDTH'(1);
                        w_wrap    = (r_bin == '0);
                    end else begin
                        w_bin_nxt = r_bin + WIDTH'(1);
                        w_wrap    = (r_bin == '1);
                    end
                    if (!bus.mode || r_stop_pend || bus.stop) begin
                        w_state_nxt     = ST_IDLE;
                        w_stop_pend_nxt = 1'b0;
                    end
                end else if (bus.stop) begin
                    // Valid is never withdrawn; remember the stop until the handshake.
                    w_stop_pend_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_stop_pend_nxt = 1'b0;
            end
        endcase
    end

    gray_enc #(
        .WIDTH (WIDTH)
    ) u_gray_enc (
        .i_bin    (r_bin),
        .o_gray_c (w_gray)
    );

    assign bus.gray_out   = w_gray;
    assign bus.gray_valid = (r_state == ST_EMIT);
    assign bus.busy       = (r_state == ST_EMIT);
    assign bus.bin_out    = r_bin;
    assign bus.wrap       = w_wrap;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl: scenario tasks drive the bus and push expected
// {gray, wrap} pairs; a negedge monitor pops and compares on every handshake.
module tb_gray_seq_ctrl;
    localparam int unsigned W = 4;

    logic clk;
    logic rst;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W:0] sb_q[$];
    logic       sb_en;
    logic [W:0] exp_item;

    logic [W-1:0] up_seq [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    gray_seq_ctrl_if #(.WIDTH(W)) dut_if ();

    gray_seq_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every accepted value must match the queue head.
    always @(negedge clk) begin
        if (!rst && sb_en) begin
            if (dut_if.gray_valid && dut_if.gray_ready) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected: handshake gray=%b with empty queue", dut_if.gray_out);
                end else begin
                    exp_item = sb_q.pop_front();
                    if ({dut_if.gray_out, dut_if.wrap} !== exp_item) begin
                        tests_failed++;
                        $display("FAIL sb_value: got gray=%b wrap=%b, expected gray=%b wrap=%b",
                                 dut_if.gray_out, dut_if.wrap, exp_item[W:1], exp_item[0]);
                    end
                end
            end else begin
                tests_run++;
                if (dut_if.wrap !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL wrap_idle: wrap=%b without handshake, expected 0", dut_if.wrap);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_init;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({dut_if.gray_out, dut_if.bin_out, dut_if.gray_valid, dut_if.busy, dut_if.wrap} !== 11'b0) begin
            tests_failed++;
            $display("FAIL reset_init: gray=%b bin=%0d valid=%b busy=%b wrap=%b, expected all zero",
                     dut_if.gray_out, dut_if.bin_out, dut_if.gray_valid, dut_if.busy, dut_if.wrap);
        end
        tick;
    endtask

    task automatic test_reset;
        sb_en = 1'b0;
        dut_if.gray_ready = 1'b1;
        dut_if.mode = 1'b1;
        dut_if.dir = 1'b0;
        dut_if.load = 1'b1;
        dut_if.load_val = 4'd6;
        dut_if.start = 1'b1;
        tick;
        dut_if.load = 1'b0;
        dut_if.start = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({dut_if.gray_out, dut_if.bin_out, dut_if.gray_valid, dut_if.busy, dut_if.wrap} !== 11'b0) begin
            tests_failed++;
            $display("FAIL reset_midrun: gray=%b bin=%0d valid=%b busy=%b wrap=%b, expected all zero",
                     dut_if.gray_out, dut_if.bin_out, dut_if.gray_valid, dut_if.busy, dut_if.wrap);
        end
        dut_if.gray_ready = 1'b0;
        dut_if.mode = 1'b0;
        tick;
        sb_en = 1'b1;
    endtask

    task automatic test_load_start;
        dut_if.mode = 1'b0;
        dut_if.dir = 1'b0;
        dut_if.gray_ready = 1'b1;
        dut_if.load = 1'b1;
        dut_if.load_val = 4'd5;
        dut_if.start = 1'b1;
        sb_q.push_back({4'b0111, 1'b0});
        tick;
        dut_if.load = 1'b0;
        dut_if.start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dut_if.gray_out !== 4'b0111 || dut_if.gray_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_start_first: gray=%b valid=%b, expected 0111 1", dut_if.gray_out, dut_if.gray_valid);
        end
        tick;
        @(negedge clk);
        tests_run++;
        if (dut_if.bin_out !== 4'd6 || dut_if.gray_valid !== 1'b0 || dut_if.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_start_after: bin=%0d valid=%b busy=%b, expected 6 0 0",
                     dut_if.bin_out, dut_if.gray_valid, dut_if.busy);
        end
        tick;
    endtask

    task automatic test_continuous;
        logic [W-1:0] prev;
        dut_if.mode = 1'b1;
        dut_if.dir = 1'b0;
        dut_if.gray_ready = 1'b1;
        dut_if.load = 1'b1;
        dut_if.load_val = 4'd0;
        dut_if.start = 1'b1;
        for (int i = 0; i < 16; i++) sb_q.push_back({up_seq[i], (i == 15)});
        sb_q.push_back({4'b0000, 1'b0});
        tick;
        dut_if.load = 1'b0;
        dut_if.start = 1'b0;
        prev = '0;
        for (int c = 0; c < 17; c++) begin
            if (c == 16) dut_if.stop = 1'b1;
            @(negedge clk);
            if (c > 0) begin
                tests_run++;
                if ($countones(prev ^ dut_if.gray_out) != 1) begin
                    tests_failed++;
                    $display("FAIL one_bit_step: %b -> %b, expected exactly one bit change", prev, dut_if.gray_out);
                end
            end
            prev = dut_if.gray_out;
            tick;
        end
        dut_if.stop = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dut_if.busy !== 1'b0 || dut_if.bin_out !== 4'd1 || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL continuous_end: busy=%b bin=%0d pending=%0d, expected 0 1 0",
                     dut_if.busy, dut_if.bin_out, sb_q.size());
        end
        tick;
    endtask

    task automatic test_backpressure;
        dut_if.mode = 1'b1;
        dut_if.dir = 1'b0;
        dut_if.gray_ready = 1'b0;
        dut_if.load = 1'b1;
        dut_if.load_val = 4'd3;
        dut_if.start = 1'b1;
        tick;
        dut_if.load = 1'b0;
        dut_if.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (dut_if.gray_out !== 4'b0010 || dut_if.gray_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL backpressure_hold: cycle %0d gray=%b valid=%b, expected 0010 1",
                         c, dut_if.gray_out, dut_if.gray_valid);
            end
            tick;
        end
        sb_q.push_back({4'b0010, 1'b0});
        sb_q.push_back({4'b0110, 1'b0});
        dut_if.gray_ready = 1'b1;
        tick;
        dut_if.stop = 1'b1;
        @(negedge clk);
        tests_run++;
        if (dut_if.gray_out !== 4'b0110) begin
            tests_failed++;
            $display("FAIL backpressure_advance: gray=%b, expected 0110", dut_if.gray_out);
        end
        tick;
        dut_if.stop = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dut_if.busy !== 1'b0 || dut_if.bin_out !== 4'd5 || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL backpressure_end: busy=%b bin=%0d pending=%0d, expected 0 5 0",
                     dut_if.busy, dut_if.bin_out, sb_q.size());
        end
        tick;
    endtask

    task automatic test_down_wrap;
        dut_if.mode = 1'b1;
        dut_if.dir = 1'b1;
        dut_if.gray_ready = 1'b1;
        dut_if.load = 1'b1;
        dut_if.load_val = 4'd0;
        dut_if.start = 1'b1;
        sb_q.push_back({4'b0000, 1'b1});
        sb_q.push_back({4'b1000, 1'b0});
        tick;
        dut_if.load = 1'b0;
        dut_if.start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dut_if.wrap !== 1'b1 || dut_if.gray_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL down_wrap_pulse: gray=%b wrap=%b, expected 0000 1", dut_if.gray_out, dut_if.wrap);
        end
        tick;
        dut_if.stop = 1'b1;
        @(negedge clk);
        tests_run++;
        if (dut_if.gray_out !== 4'b1000 || dut_if.bin_out !== 4'd15) begin
            tests_failed++;
            $display("FAIL down_wrap_next: gray=%b bin=%0d, expected 1000 15", dut_if.gray_out, dut_if.bin_out);
        end
        tick;
        dut_if.stop = 1'b0;
        dut_if.dir = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dut_if.busy !== 1'b0 || dut_if.bin_out !== 4'd14) begin
            tests_failed++;
            $display("FAIL down_wrap_end: busy=%b bin=%0d, expected 0 14", dut_if.busy, dut_if.bin_out);
        end
        tick;
    endtask

    task automatic test_stop_backpressure;
        dut_if.mode = 1'b1;
        dut_if.dir = 1'b0;
        dut_if.gray_ready = 1'b0;
        dut_if.load = 1'b1;
        dut_if.load_val = 4'd8;
        dut_if.start = 1'b1;
        tick;
        dut_if.load = 1'b0;
        dut_if.start = 1'b0;
        dut_if.stop = 1'b1;
        tick;
        dut_if.stop = 1'b0;
        dut_if.start = 1'b1;
        @(negedge clk);
        tests_run++;
        if (dut_if.gray_out !== 4'b1100 || dut_if.gray_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stop_hold: gray=%b valid=%b, expected 1100 1", dut_if.gray_out, dut_if.gray_valid);
        end
        tick;
        dut_if.start = 1'b0;
        dut_if.gray_ready = 1'b1;
        sb_q.push_back({4'b1100, 1'b0});
        tick;
        @(negedge clk);
        tests_run++;
        if (dut_if.busy !== 1'b0 || dut_if.gray_valid !== 1'b0 || dut_if.bin_out !== 4'd9) begin
            tests_failed++;
            $display("FAIL stop_idle: busy=%b valid=%b bin=%0d, expected 0 0 9",
                     dut_if.busy, dut_if.gray_valid, dut_if.bin_out);
        end
        tick;
        dut_if.mode = 1'b0;
        dut_if.start = 1'b1;
        sb_q.push_back({4'b1101, 1'b0});
        tick;
        dut_if.start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dut_if.gray_out !== 4'b1101 || dut_if.gray_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_value: gray=%b valid=%b, expected 1101 1", dut_if.gray_out, dut_if.gray_valid);
        end
        tick;
        @(negedge clk);
        tests_run++;
        if (dut_if.busy !== 1'b0 || dut_if.bin_out !== 4'd10 || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL restart_end: busy=%b bin=%0d pending=%0d, expected 0 10 0",
                     dut_if.busy, dut_if.bin_out, sb_q.size());
        end
        tick;
    endtask

    initial begin
        rst = 1'b1;
        sb_en = 1'b0;
        dut_if.start = 1'b0;
        dut_if.stop = 1'b0;
        dut_if.mode = 1'b0;
        dut_if.dir = 1'b0;
        dut_if.load = 1'b0;
        dut_if.load_val = '0;
        dut_if.gray_ready = 1'b0;

        test_reset_init;
        sb_en = 1'b1;
        test_reset;
        test_load_start;
        test_continuous;
        test_backpressure;
        test_down_wrap;
        test_stop_backpressure;

        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: %0d expected values never accepted, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
